hazard_scoreboard: RTL

// Parametrised hazard/forwarding unit for the pipelined MIPS datapath; replaces the inline stall-only

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_scoreboard_if.sv | 14 +
 rtl/hazard_match.sv | 27 ++
 rtl/hazard_scoreboard.sv | 52 +++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the hazard/forwarding scoreboard
package hazard_pkg;
  localparam int FWD_RF = 0;
  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side request and hazard/forward response bundle
interface hazard_scoreboard_if #(parameter int REG_W = 5, parameter int STAGES = 3, parameter int CNT_W = 16);
  import hazard_pkg::*;
  localparam int SW = sel_w(STAGES);
  logic adv, flush, id_valid, id_use_rs, id_use_rt, id_wen, id_is_load;
  logic [REG_W-1:0] id_rs, id_rt, id_wsel;
  logic stall;
  logic [SW-1:0] fwd_rs, fwd_rt, busy_cnt;
  logic [CNT_W-1:0] stall_cnt;
  modport master(output adv, flush, id_valid, id_use_rs, id_use_rt, id_wen, id_is_load, id_rs, id_rt, id_wsel,
                 input stall, fwd_rs, fwd_rt, busy_cnt, stall_cnt);
  modport slave(input adv, flush, id_valid, id_use_rs, id_use_rt, id_wen, id_is_load, id_rs, id_rt, id_wsel,
                output stall, fwd_rs, fwd_rt, busy_cnt, stall_cnt);
endinterface

// File: rtl/hazard_match.sv
// hazard_match: youngest in-flight writer match and ready/stall decision for one source operand
module hazard_match import hazard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int LOAD_LAT = 1,
  localparam int SW = sel_w(STAGES)
) (
  input  logic              use_reg,
  input  logic [REG_W-1:0]  id_reg,
  input  logic [STAGES-1:0] valid,
  input  logic [STAGES-1:0] is_load,
  input  logic [REG_W-1:0]  wsel [STAGES],
  output logic [SW-1:0]     fwd,
  output logic              stl
);
  // scan oldest to youngest so the youngest match overwrites the decision last
  always_comb begin
    fwd = SW'(FWD_RF);
    stl = 1'b0;
    for (int k = STAGES; k >= 1; k--)
      if (use_reg && id_reg != '0 && valid[k-1] && wsel[k-1] == id_reg) begin
        stl = FWD_EN == 0 || (is_load[k-1] && k < 1 + LOAD_LAT);
        fwd = stl ? SW'(FWD_RF) : SW'(k);
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer shift scoreboard producing decode stall and forward selects
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int STAGES = 3,
  parameter int FWD_EN = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16,
  localparam int SW = sel_w(STAGES)
) (
  input logic CLK,
  input logic RST,
  hazard_scoreboard_if.slave bus
);
  typedef struct packed {logic valid; logic [REG_W-1:0] wsel; logic is_load;} entry_t;
  entry_t sb [STAGES];
  logic [STAGES-1:0] valid, is_load;
  logic [REG_W-1:0] wsel [STAGES];
  logic stl_rs, stl_rt, ins;
  logic [SW-1:0] f_rs, f_rt, busy;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    busy = '0;
    for (int k = 0; k < STAGES; k++) begin
      valid[k] = sb[k].valid;
      is_load[k] = sb[k].is_load;
      wsel[k] = sb[k].wsel;
      busy = busy + SW'(sb[k].valid);
    end
  end
  hazard_match #(.REG_W(REG_W), .STAGES(STAGES), .FWD_EN(FWD_EN), .LOAD_LAT(LOAD_LAT)) u_rs (
    .use_reg(bus.id_use_rs), .id_reg(bus.id_rs), .valid(valid), .is_load(is_load), .wsel(wsel),
    .fwd(f_rs), .stl(stl_rs));
  hazard_match #(.REG_W(REG_W), .STAGES(STAGES), .FWD_EN(FWD_EN), .LOAD_LAT(LOAD_LAT)) u_rt (
    .use_reg(bus.id_use_rt), .id_reg(bus.id_rt), .valid(valid), .is_load(is_load), .wsel(wsel),
    .fwd(f_rt), .stl(stl_rt));
  assign bus.stall = bus.id_valid && !bus.flush && (stl_rs || stl_rt);
  assign bus.fwd_rs = bus.stall ? SW'(FWD_RF) : f_rs;
  assign bus.fwd_rt = bus.stall ? SW'(FWD_RF) : f_rt;
  assign bus.busy_cnt = busy;
  assign bus.stall_cnt = cnt;
  // a stalled or flushed decode slot enters the pipe as a bubble
  assign ins = bus.id_valid && bus.id_wen && |bus.id_wsel && !bus.stall && !bus.flush;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int k = 0; k < STAGES; k++) sb[k] <= '0;
      cnt <= '0;
    end else if (bus.adv) begin
      sb[0] <= '{valid: ins, wsel: bus.id_wsel, is_load: bus.id_is_load};
      for (int k = 1; k < STAGES; k++) sb[k] <= sb[k-1];
      if (bus.stall && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
endmodule
